// File: rtl/pg_gen_stage.sv
// pg_gen_stage: registered generate/propagate pre-processing stage for the vector adder.
// This stage sits directly upstream of the parallel-prefix tree. It conditions B for
// subtract and folds the carry-in into each lane's LSB generate. It also kills the
// propagate at every lane LSB, so the tree can never carry across a lane boundary.
// Beats are buffered in an output register (OR) with one skid register (SK) behind it.
//
// Ports
//   clk, rst               rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    upstream handshake (in_ready is registered, = !SK full)
//   in_a, in_b             operands, WIDTH bits
//   in_sub                 0 = A+B, 1 = A-B (A + ~B + 1 per lane)
//   in_mode                lane size: 00 = 64b, 01 = 32b, 10 = 16b, 11 = 8b
//   in_tag                 opaque tag carried with the beat
//   out_valid / out_ready  downstream handshake (out_valid = OR full)
//   out_g, out_p, out_x    generate (cin folded), tree propagate, half-sum
//   out_sub, out_mode, out_tag   registered copies of the control fields
module pg_gen_stage #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_g,
    output logic [WIDTH-1:0] out_p,
    output logic [WIDTH-1:0] out_x,
    output logic             out_sub,
    output logic [1:0]       out_mode,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned SLICES = WIDTH / 64;

    // Lane-LSB patterns for one 64b slice; lane 0 always starts at bit 0.
    localparam logic [63:0] LSB_64 = 64'h0000_0000_0000_0001;
    localparam logic [63:0] LSB_32 = 64'h0000_0001_0000_0001;
    localparam logic [63:0] LSB_16 = 64'h0001_0001_0001_0001;
    localparam logic [63:0] LSB_8  = 64'h0101_0101_0101_0101;

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] x;
        logic             sub;
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
    } beat_t;

    // Occupancy: S_ONE = OR full and SK empty, S_TWO = both full.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    beat_t            or_q;
    beat_t            sk_q;
    beat_t            in_beat;
    logic [WIDTH-1:0] lsb_mask;
    logic [WIDTH-1:0] b_cond;
    logic             accept;
    logic             drain;
    logic             load_or;
    logic             load_or_from_sk;
    logic             load_sk;

    // Lane LSB mask for the requested mode, tiled across every 64b slice.
    always_comb begin
        lsb_mask = '0;
        unique case (in_mode)
            2'b00:   lsb_mask = {SLICES{LSB_64}};
            2'b01:   lsb_mask = {SLICES{LSB_32}};
            2'b10:   lsb_mask = {SLICES{LSB_16}};
            default: lsb_mask = {SLICES{LSB_8}};
        endcase
    end

    // Generate/propagate/half-sum for the incoming beat.
    // On subtract, the +1 is the lane carry-in. A carry-in of 1 at the lane LSB makes
    // g = a&b' | x, so x is ORed into g there. p is cleared at the lane LSB to stop any
    // carry entering the lane from below.
    always_comb begin
        b_cond       = in_sub ? ~in_b : in_b;
        in_beat      = '0;
        in_beat.x    = in_a ^ b_cond;
        in_beat.g    = (in_a & b_cond) | (in_beat.x & lsb_mask & {WIDTH{in_sub}});
        in_beat.p    = in_beat.x & ~lsb_mask;
        in_beat.sub  = in_sub;
        in_beat.mode = in_mode;
        in_beat.tag  = in_tag;
    end

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next occupancy and the load controls for OR and SK.
    always_comb begin
        state_next      = state;
        load_or         = 1'b0;
        load_or_from_sk = 1'b0;
        load_sk         = 1'b0;
        unique case (state)
            S_EMPTY: begin
                if (accept) begin
                    load_or    = 1'b1;
                    state_next = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && drain) begin
                    load_or = 1'b1;
                end else if (accept) begin
                    load_sk    = 1'b1;
                    state_next = S_TWO;
                end else if (drain) begin
                    state_next = S_EMPTY;
                end
            end
            S_TWO: begin
                // in_ready is low here, so only a drain can happen.
                if (drain) begin
                    load_or         = 1'b1;
                    load_or_from_sk = 1'b1;
                    state_next      = S_ONE;
                end
            end
            default: begin
                state_next = S_EMPTY;
            end
        endcase
    end

    // Handshake flags are registered copies of the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next != S_TWO);
            out_valid <= (state_next != S_EMPTY);
        end
    end

    // Payload registers: OR feeds the outputs, SK catches one beat during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            or_q <= '0;
            sk_q <= '0;
        end else begin
            if (load_or) begin
                or_q <= load_or_from_sk ? sk_q : in_beat;
            end
            if (load_sk) begin
                sk_q <= in_beat;
            end
        end
    end

    assign out_g    = or_q.g;
    assign out_p    = or_q.p;
    assign out_x    = or_q.x;
    assign out_sub  = or_q.sub;
    assign out_mode = or_q.mode;
    assign out_tag  = or_q.tag;

endmodule
